red_pitaya_exp_in_cond: RTL and testbench

Input conditioner for the expansion connector, placed directly upstream of the housekeeping register block.
- Synchronises raw connector pins to clk_i and debounces each bit with a programmable hold time.
- Detects rising and falling edges and keeps sticky, maskable per-bit event flags with an aggregate interrupt.
- dat_o feeds the housekeeping exp_p_dat_i / exp_n_dat_i read path. The top level uses one instance per connector bank.

---
 rtl/red_pitaya_exp_in_cond_pkg.sv | 14 +
 rtl/red_pitaya_exp_deb_bit.sv | 53 +++++
 rtl/red_pitaya_exp_in_cond.sv | 54 +++++
 tb/tb_red_pitaya_exp_in_cond.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_exp_in_cond_pkg.sv
// Shared constants for the expansion-connector input conditioner.
// Also holds the pin-to-dat_o latency helper.
package red_pitaya_exp_in_cond_pkg;

  localparam int DEF_DW          = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;

  // Cycles from a clean pin change until the new level shows on dat_o.
  function automatic int deb_latency(input int sync_stages, input int deb);
    return sync_stages + deb + 1;
  endfunction

endpackage

// File: rtl/red_pitaya_exp_deb_bit.sv
// One conditioned input bit: synchroniser chain, debounce counter and edge pulses.
// The level commits only after staying different from dat_o for cfg_deb_i+1 cycles.
module red_pitaya_exp_deb_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pin_i,
  input  logic [CNT_W-1:0] cfg_deb_i,
  output logic             dat_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  // The >= compare lets a lowered threshold commit at once; saturation avoids wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      dat_o  <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (sync == dat_o) begin
        cnt <= '0;
      end else if (cnt >= cfg_deb_i) begin
        dat_o  <= sync;
        cnt    <= '0;
        rise_o <= sync;
        fall_o <= ~sync;
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/red_pitaya_exp_in_cond.sv
// Expansion-connector input conditioner: per-bit debounce plus sticky, maskable
// edge event flags with a registered aggregate interrupt.
module red_pitaya_exp_in_cond
  import red_pitaya_exp_in_cond_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DW-1:0]    exp_dat_i,
  input  logic [CNT_W-1:0] cfg_deb_i,
  input  logic [DW-1:0]    cfg_rise_en_i,
  input  logic [DW-1:0]    cfg_fall_en_i,
  input  logic [DW-1:0]    evt_clr_i,
  output logic [DW-1:0]    dat_o,
  output logic [DW-1:0]    rise_o,
  output logic [DW-1:0]    fall_o,
  output logic [DW-1:0]    evt_o,
  output logic             irq_o
);

  logic [DW-1:0] evt_set;

  for (genvar g = 0; g < DW; g++) begin : g_bit
    red_pitaya_exp_deb_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_deb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .pin_i     (exp_dat_i[g]),
      .cfg_deb_i (cfg_deb_i),
      .dat_o     (dat_o[g]),
      .rise_o    (rise_o[g]),
      .fall_o    (fall_o[g])
    );
  end

  assign evt_set = (rise_o & cfg_rise_en_i) | (fall_o & cfg_fall_en_i);

  // A new event wins over a clear landing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_o <= '0;
      irq_o <= 1'b0;
    end else begin
      evt_o <= (evt_o & ~evt_clr_i) | evt_set;
      irq_o <= |evt_o;
    end
  end

endmodule

// File: tb/tb_red_pitaya_exp_in_cond.sv
// Directed bench for the input conditioner: stimulus schedules hand-computed
// expectations per cycle into a scoreboard that a negedge monitor drains.
module tb_red_pitaya_exp_in_cond;
  import red_pitaya_exp_in_cond_pkg::*;

  localparam int DW = DEF_DW;
  localparam int SS = DEF_SYNC_STAGES;
  localparam int CW = DEF_CNT_W;

  localparam int SIG_DAT  = 0;
  localparam int SIG_RISE = 1;
  localparam int SIG_FALL = 2;
  localparam int SIG_EVT  = 3;
  localparam int SIG_IRQ  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] exp_dat_i;
  logic [CW-1:0] cfg_deb_i;
  logic [DW-1:0] cfg_rise_en_i;
  logic [DW-1:0] cfg_fall_en_i;
  logic [DW-1:0] evt_clr_i;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] rise_o;
  logic [DW-1:0] fall_o;
  logic [DW-1:0] evt_o;
  logic          irq_o;

  red_pitaya_exp_in_cond dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .exp_dat_i     (exp_dat_i),
    .cfg_deb_i     (cfg_deb_i),
    .cfg_rise_en_i (cfg_rise_en_i),
    .cfg_fall_en_i (cfg_fall_en_i),
    .evt_clr_i     (evt_clr_i),
    .dat_o         (dat_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .evt_o         (evt_o),
    .irq_o         (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int            at;
    int            sig;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mon_act;

  task automatic expect_at(input int at, input int sig, input logic [DW-1:0] val);
    exp_t e;
    e.at  = at;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [DW-1:0] observe(input int sig);
    case (sig)
      SIG_DAT:  return dat_o;
      SIG_RISE: return rise_o;
      SIG_FALL: return fall_o;
      SIG_EVT:  return evt_o;
      default:  return {{(DW-1){1'b0}}, irq_o};
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      SIG_DAT:  return "dat_o";
      SIG_RISE: return "rise_o";
      SIG_FALL: return "fall_o";
      SIG_EVT:  return "evt_o";
      default:  return "irq_o";
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk_i) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        mon_act = observe(sb[i].sig);
        checks++;
        if (sb[i].at < cyc) begin
          errors++;
          $display("[TB] FAIL %s @%0d: not sampled in time (now %0d), required %h",
                   sig_name(sb[i].sig), sb[i].at, cyc, sb[i].val);
        end else if (mon_act !== sb[i].val) begin
          errors++;
          $display("[TB] FAIL %s @%0d: got %h, required %h",
                   sig_name(sb[i].sig), sb[i].at, mon_act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_until(input int at);
    while (cyc < at) tick(1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not end, got cycle %0d, required < 10000", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int lat;

    // 1: reset values, then one clean rise and fall on bit0
    rst_i = 1'b1; exp_dat_i = '0; cfg_deb_i = 16'd3;
    cfg_rise_en_i = '0; cfg_fall_en_i = '0; evt_clr_i = '0;
    tick(2);
    t = cyc;
    expect_at(t, SIG_DAT, 8'h00);  expect_at(t, SIG_RISE, 8'h00);
    expect_at(t, SIG_FALL, 8'h00); expect_at(t, SIG_EVT, 8'h00);
    expect_at(t, SIG_IRQ, 8'h00);
    rst_i = 1'b0;
    tick(8);
    lat = deb_latency(SS, 3);
    t = cyc;
    expect_at(t + lat - 1, SIG_DAT, 8'h00);  expect_at(t + lat, SIG_DAT, 8'h01);
    expect_at(t + lat - 1, SIG_RISE, 8'h00); expect_at(t + lat, SIG_RISE, 8'h01);
    expect_at(t + lat + 1, SIG_RISE, 8'h00); expect_at(t + lat, SIG_FALL, 8'h00);
    exp_dat_i[0] = 1'b1;
    tick(lat + 3);
    t = cyc;
    expect_at(t + lat - 1, SIG_DAT, 8'h01);  expect_at(t + lat, SIG_DAT, 8'h00);
    expect_at(t + lat, SIG_FALL, 8'h01);     expect_at(t + lat + 1, SIG_FALL, 8'h00);
    exp_dat_i[0] = 1'b0;
    tick(lat + 3);

    // 2: 3-cycle glitch rejected, held level commits, 2-cycle dropout rejected
    t = cyc;
    for (int k = 1; k <= lat + 4; k++) begin
      expect_at(t + k, SIG_DAT, 8'h00);
      expect_at(t + k, SIG_RISE, 8'h00);
      expect_at(t + k, SIG_FALL, 8'h00);
    end
    exp_dat_i[5] = 1'b1;
    tick(3);
    exp_dat_i[5] = 1'b0;
    tick(lat + 5);
    t = cyc;
    expect_at(t + lat - 1, SIG_DAT, 8'h00);
    expect_at(t + lat, SIG_DAT, 8'h20);
    expect_at(t + lat, SIG_RISE, 8'h20);
    for (int k = lat + 1; k <= lat + 14; k++) begin
      expect_at(t + k, SIG_DAT, 8'h20);
      expect_at(t + k, SIG_FALL, 8'h00);
    end
    exp_dat_i[5] = 1'b1;
    tick(10);
    exp_dat_i[5] = 1'b0;
    tick(2);
    exp_dat_i[5] = 1'b1;
    wait_until(t + lat + 15);
    t = cyc;
    expect_at(t + lat, SIG_DAT, 8'h00);
    expect_at(t + lat, SIG_FALL, 8'h20);
    exp_dat_i[5] = 1'b0;
    tick(lat + 3);

    // 3: zero threshold, bit2 toggled every 4 cycles
    cfg_deb_i = 16'd0;
    lat = deb_latency(SS, 0);
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      expect_at(t + 4 * k + lat, SIG_DAT,  (k % 2 == 0) ? 8'h04 : 8'h00);
      expect_at(t + 4 * k + lat, SIG_RISE, (k % 2 == 0) ? 8'h04 : 8'h00);
      expect_at(t + 4 * k + lat, SIG_FALL, (k % 2 == 0) ? 8'h00 : 8'h04);
      expect_at(t + 4 * k + lat + 1, SIG_RISE, 8'h00);
      expect_at(t + 4 * k + lat + 1, SIG_FALL, 8'h00);
    end
    for (int k = 0; k < 4; k++) begin
      exp_dat_i[2] = (k % 2 == 0);
      tick(4);
    end
    tick(4);

    // 4: masked event flags and irq
    cfg_deb_i = 16'd3;
    lat = deb_latency(SS, 3);
    cfg_rise_en_i = 8'h01;
    cfg_fall_en_i = 8'h02;
    tick(2);
    t = cyc;
    expect_at(t + lat, SIG_RISE, 8'h03);
    expect_at(t + lat, SIG_EVT, 8'h00);
    expect_at(t + lat + 1, SIG_EVT, 8'h01);
    expect_at(t + lat + 1, SIG_IRQ, 8'h00);
    expect_at(t + lat + 2, SIG_IRQ, 8'h01);
    exp_dat_i[1:0] = 2'b11;
    tick(lat + 4);
    t = cyc;
    expect_at(t + lat, SIG_FALL, 8'h02);
    expect_at(t + lat, SIG_EVT, 8'h01);
    expect_at(t + lat + 1, SIG_EVT, 8'h03);
    expect_at(t + lat + 1, SIG_IRQ, 8'h01);
    exp_dat_i[1] = 1'b0;
    tick(lat + 4);

    // 5: set beats simultaneous clear, then lone clears drop evt and irq
    t = cyc;
    expect_at(t + lat + 2, SIG_EVT, 8'h03);
    exp_dat_i[0] = 1'b0;
    tick(lat + 4);
    t = cyc;
    expect_at(t + lat, SIG_RISE, 8'h01);
    expect_at(t + lat + 1, SIG_EVT, 8'h03);
    exp_dat_i[0] = 1'b1;
    wait_until(t + lat);
    evt_clr_i = 8'h01;
    tick(1);
    evt_clr_i = 8'h00;
    tick(3);
    t = cyc;
    expect_at(t + 1, SIG_EVT, 8'h02);
    expect_at(t + 1, SIG_IRQ, 8'h01);
    evt_clr_i = 8'h01;
    tick(1);
    evt_clr_i = 8'h00;
    tick(2);
    t = cyc;
    expect_at(t + 1, SIG_EVT, 8'h00);
    expect_at(t + 1, SIG_IRQ, 8'h01);
    expect_at(t + 2, SIG_IRQ, 8'h00);
    evt_clr_i = 8'h02;
    tick(1);
    evt_clr_i = 8'h00;
    tick(3);

    // 6: reset mid-count on bit3 restarts the full latency; bit0 pin still high
    t = cyc;
    expect_at(t + 4, SIG_DAT, 8'h00);  expect_at(t + 4, SIG_RISE, 8'h00);
    expect_at(t + 4, SIG_FALL, 8'h00); expect_at(t + 4, SIG_EVT, 8'h00);
    expect_at(t + 4, SIG_IRQ, 8'h00);
    expect_at(t + 6, SIG_DAT, 8'h00);
    expect_at(t + 3 + lat, SIG_DAT, 8'h00);
    expect_at(t + 4 + lat, SIG_DAT, 8'h09);
    expect_at(t + 4 + lat, SIG_RISE, 8'h09);
    expect_at(t + 5 + lat, SIG_RISE, 8'h00);
    expect_at(t + 5 + lat, SIG_EVT, 8'h01);
    expect_at(t + 6 + lat, SIG_IRQ, 8'h01);
    exp_dat_i[3] = 1'b1;
    wait_until(t + 3);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    tick(lat + 8);

    // 7: lowering the threshold mid-count commits on the next differing cycle
    cfg_deb_i = 16'd10;
    t = cyc;
    expect_at(t + 3, SIG_DAT, 8'h09);
    expect_at(t + 4, SIG_DAT, 8'h89);
    expect_at(t + 4, SIG_RISE, 8'h80);
    exp_dat_i[7] = 1'b1;
    wait_until(t + 3);
    cfg_deb_i = 16'd1;
    tick(6);

    tick(2);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s @%0d: never checked, required %h",
               sig_name(sb[0].sig), sb[0].at, sb[0].val);
      void'(sb.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
